// File: rtl/macro_fifo4_ptrq_if.sv
`default_nettype none
// ============================================================================
//  Module   : macro_fifo4_ptrq_if
//  Purpose  : Valid/ready handshake bundle for the 4-entry pointer FIFO.
//             Write side: i_valid / i_ready / i_data.
//             Read side : o_valid / o_ready / o_data, plus o_count occupancy.
//  Modports : master - producer/consumer side (drives i_valid, i_data, o_ready)
//             slave  - FIFO side (drives i_ready, o_valid, o_data, o_count)
//  Revision : 1.0 - initial release
// ============================================================================
interface macro_fifo4_ptrq_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_data;
  logic [2:0]       o_count;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data, o_count
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data, o_count
  );
endinterface
`default_nettype wire

// File: rtl/macro_fifo4_ptrq.sv
`default_nettype none
// ============================================================================
//  Module   : macro_rom_incr2
//  Purpose  : 2-bit wrapping increment table. q = a+1 mod 4, c = 1 on 3->0.
//  Ports    : a (in, 2) current pointer; q (out, 2) next pointer;
//             c (out, 1) wrap carry
//  Revision : 1.0 - initial release
// ============================================================================
module macro_rom_incr2 (
  input  logic [1:0] a,
  output logic [1:0] q,
  output logic       c
);
  always_comb begin
    q = 2'd0;
    c = 1'b0;
    case (a)
      2'd0: begin q = 2'd1; c = 1'b0; end
      2'd1: begin q = 2'd2; c = 1'b0; end
      2'd2: begin q = 2'd3; c = 1'b0; end
      default: begin q = 2'd0; c = 1'b1; end
    endcase
  end
endmodule

// ============================================================================
//  Module   : macro_fifo4_ptrq
//  Purpose  : 4-entry synchronous FIFO with 2-bit wrapping pointers plus a
//             wrap bit per pointer to tell full from empty. Combinational
//             read of the head entry, no bypass.
//  Ports    : clk    (in)  rising-edge clock
//             resetn (in)  synchronous active-low reset
//             bus    (slave modport) i_valid/i_ready/i_data write side,
//                    o_valid/o_ready/o_data read side, o_count occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module macro_fifo4_ptrq #(
  parameter int WIDTH = 32
) (
  input  wire                 clk,
  input  wire                 resetn,
  macro_fifo4_ptrq_if.slave   bus
);
  logic [1:0]       r_wptr;
  logic [1:0]       r_rptr;
  logic             r_wwrap;
  logic             r_rwrap;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_mem [0:3];

  logic [1:0]       w_wq;
  logic             w_wc;
  logic [1:0]       w_rq;
  logic             w_rc;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_occ;

  macro_rom_incr2 u_wincr (.a(r_wptr), .q(w_wq), .c(w_wc));
  macro_rom_incr2 u_rincr (.a(r_rptr), .q(w_rq), .c(w_rc));

  // Equal pointers mean empty or full; the wrap bits break the tie.
  assign w_empty = (r_wptr == r_rptr) && (r_wwrap == r_rwrap);
  assign w_full  = (r_wptr == r_rptr) && (r_wwrap != r_rwrap);

  // Flags come only from registered state, so handshakes never loop back.
  assign bus.i_ready = !w_full;
  assign bus.o_valid = !w_empty;
  assign bus.o_data  = r_mem[r_rptr];
  assign bus.o_count = r_cnt;

  assign w_push = bus.i_valid && !w_full;
  assign w_pop  = bus.o_ready && !w_empty;

  // Occupancy implied by the pointers; must always match the counter.
  assign w_occ = {r_wwrap ^ r_rwrap, r_wptr} - {1'b0, r_rptr};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_wwrap <= 1'b0;
      r_rwrap <= 1'b0;
      r_cnt   <= 3'd0;
    end else begin
      if (w_push) begin
        r_wptr  <= w_wq;
        r_wwrap <= r_wwrap ^ w_wc;
      end
      if (w_pop) begin
        r_rptr  <= w_rq;
        r_rwrap <= r_rwrap ^ w_rc;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (resetn && w_push) begin
      r_mem[r_wptr] <= bus.i_data;
    end
  end

  a_cnt_matches_ptrs: assert property (
    @(posedge clk) disable iff (!resetn) r_cnt == w_occ
  );
endmodule
`default_nettype wire

// File: tb/tb_macro_fifo4_ptrq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_macro_fifo4_ptrq
//  Purpose  : Self-checking bench for macro_fifo4_ptrq. An occupancy model
//             and a data queue predict flags, count and head data each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_macro_fifo4_ptrq;
  localparam int WIDTH = 32;

  logic clk;
  logic resetn;

  macro_fifo4_ptrq_if #(.WIDTH(WIDTH)) bus ();

  macro_fifo4_ptrq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] exp_q [$];
  int               m_cnt = 0;
  bit               armed = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
  endtask

  // Model evaluated mid-cycle, after inputs settle and away from the edge.
  always @(negedge clk) begin
    bit push_f;
    bit pop_f;
    logic [WIDTH-1:0] head;
    if (armed) begin
      check("i_ready", {63'd0, bus.i_ready}, {63'd0, (m_cnt < 4)});
      check("o_valid", {63'd0, bus.o_valid}, {63'd0, (m_cnt > 0)});
      check("o_count", {61'd0, bus.o_count}, 64'(m_cnt));
    end
    if (!resetn) begin
      exp_q.delete();
      m_cnt = 0;
      armed = 1'b1;
    end else if (armed) begin
      push_f = bus.i_valid && (m_cnt < 4);
      pop_f  = bus.o_ready && (m_cnt > 0);
      if (pop_f) begin
        head = exp_q.pop_front();
        check("o_data", 64'(bus.o_data), 64'(head));
      end
      if (push_f) exp_q.push_back(bus.i_data);
      if (push_f && !pop_f) m_cnt++;
      if (pop_f && !push_f) m_cnt--;
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.o_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn      = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // 1. idle after reset
    repeat (3) drive(1'b0, '0, 1'b0);

    // 2. fill with o_ready low; 5th offer is held and ignored
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    drive(1'b1, 32'hA000_0005, 1'b0);
    drive(1'b0, '0, 1'b0);

    // 3. drain A1..A4
    repeat (4) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // 4. stream 10 words, pointers wrap twice
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom, 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // 5. full, then push+pop offered together
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 1'b0);
    drive(1'b1, 32'hC000_0010, 1'b1);
    drive(1'b1, 32'hC000_0010, 1'b1);
    drive(1'b1, 32'hC000_0011, 1'b1);
    repeat (5) drive(1'b0, '0, 1'b1);

    // 6. reset mid-stream with two words stored
    drive(1'b1, 32'hD000_0001, 1'b0);
    drive(1'b1, 32'hD000_0002, 1'b0);
    bus.i_valid = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 32'hB000_0001, 1'b0);
    drive(1'b0, '0, 1'b0);
    check("b1_head", 64'(bus.o_data), 64'(32'hB000_0001));
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
